// File: rtl/controle_pkg.sv
// controle_pkg -- shared definitions for the controle sequencer and the
// operativo datapath it drives.
//   * State encoding of the controle FSM (3-bit, legacy-compatible constants).
//   * Named mux-select constants for mux-0, mux-1 (ULA left) and mux-2
//     (ULA right), plus the ULA operation codes.
//   * ctrl_t: the bundle of Moore-decoded control outputs.
package controle_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOADX = 3'd1;
    localparam logic [2:0] ST_CALCH = 3'd2;
    localparam logic [2:0] ST_CLRS  = 3'd3;
    localparam logic [2:0] ST_LOOP  = 3'd4;
    localparam logic [2:0] ST_ADDA  = 3'd5;
    localparam logic [2:0] ST_SUBC  = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // mux-0: constant/input operand
    localparam logic [1:0] SEL0_ZERO = 2'b00;
    localparam logic [1:0] SEL0_A    = 2'b01;
    localparam logic [1:0] SEL0_B    = 2'b10;
    localparam logic [1:0] SEL0_C    = 2'b11;

    // mux-1: ULA left operand
    localparam logic [1:0] SEL1_MUX0 = 2'b00;
    localparam logic [1:0] SEL1_X    = 2'b01;
    localparam logic [1:0] SEL1_S    = 2'b10;
    localparam logic [1:0] SEL1_H    = 2'b11;

    // mux-2: ULA right operand
    localparam logic [1:0] SEL2_X    = 2'b00;
    localparam logic [1:0] SEL2_MUX0 = 2'b01;
    localparam logic [1:0] SEL2_S    = 2'b10;
    localparam logic [1:0] SEL2_H    = 2'b11;

    // ULA operation (16-bit wrap-around)
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic       lx;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       ls;
        logic       lh;
        logic       pronto;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/controle_if.sv
// controle_if -- handshake and control bus between a host, the controle
// sequencer and the operativo datapath.
//   inicio, n           : start request and iteration count (host -> controle)
//   lx, ls, lh          : register load enables for X, S and H
//   m0, m1, m2          : datapath mux selects
//   h                   : ULA operation (0 add, 1 subtract)
//   pronto              : one-cycle completion pulse
//   ocupado             : sequencer busy (not IDLE)
// modport master: the host side; modport slave: the controle side.
interface controle_if #(
    parameter int N_W = 4
);
    logic           inicio;
    logic [N_W-1:0] n;
    logic           lx;
    logic [1:0]     m0;
    logic [1:0]     m1;
    logic [1:0]     m2;
    logic           h;
    logic           ls;
    logic           lh;
    logic           pronto;
    logic           ocupado;

    modport master (
        output inicio, n,
        input  lx, m0, m1, m2, h, ls, lh, pronto, ocupado
    );

    modport slave (
        input  inicio, n,
        output lx, m0, m1, m2, h, ls, lh, pronto, ocupado
    );
endinterface

// File: rtl/controle_contador.sv
// controle_contador -- the contador: N_W-bit down-counter holding the
// remaining iteration count of the controle sequencer.
//   ck    : clock (rising edge)
//   rst   : synchronous active-high reset, clears the count
//   carga : load d into the counter (has priority over dec)
//   dec   : decrement by one
//   d     : load value
//   cnt   : current count
//   zero  : cnt == 0
module controle_contador #(
    parameter int N_W = 4
) (
    input  logic           ck,
    input  logic           rst,
    input  logic           carga,
    input  logic           dec,
    input  logic [N_W-1:0] d,
    output logic [N_W-1:0] cnt,
    output logic           zero
);
    localparam logic [N_W-1:0] UM = N_W'(1);

    always_ff @(posedge ck) begin
        if (rst) begin
            cnt <= '0;
        end else if (carga) begin
            cnt <= d;
        end else if (dec) begin
            cnt <= cnt - UM;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/controle.sv
// controle -- sequencer for the operativo datapath computing
//   Resultado = n*(X+B) + A - C  (mod 2^16)
// Sequence: IDLE -> LOADX -> CALCH (H=B+X) -> CLRS (S=0) -> LOOP x n
// (S=S+H) -> ADDA (S=A+S) -> SUBC (S=S-C) -> DONE (pronto) -> IDLE.
// All outputs are Moore-decoded from the state register.
//   ck  : clock (rising edge)
//   rst : synchronous active-high reset, forces IDLE and clears the count
//   bus : controle_if slave modport (inicio/n in, control outputs out);
//         its N_W must match this module's N_W
module controle
    import controle_pkg::*;
#(
    parameter int N_W = 4
) (
    input  logic ck,
    input  logic rst,
    controle_if.slave bus
);
    localparam logic [N_W-1:0] CNT_UM = N_W'(1);

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [N_W-1:0] cnt;
    logic           cnt_zero;
    logic           cnt_carga;
    logic           cnt_dec;
    ctrl_t          ctrl;

    // Moore output decode; anything not named for a state stays 0.
    function automatic ctrl_t decode(input logic [2:0] st);
        ctrl_t c;
        c = CTRL_NONE;
        case (st)
            ST_LOADX: c.lx = 1'b1;
            ST_CALCH: begin
                c.m0 = SEL0_B;
                c.m1 = SEL1_MUX0;
                c.m2 = SEL2_X;
                c.h  = OP_ADD;
                c.lh = 1'b1;
            end
            ST_CLRS: begin
                c.m0 = SEL0_ZERO;
                c.m1 = SEL1_MUX0;
                c.m2 = SEL2_MUX0;
                c.h  = OP_ADD;
                c.ls = 1'b1;
            end
            ST_LOOP: begin
                c.m1 = SEL1_S;
                c.m2 = SEL2_H;
                c.h  = OP_ADD;
                c.ls = 1'b1;
            end
            ST_ADDA: begin
                c.m0 = SEL0_A;
                c.m1 = SEL1_MUX0;
                c.m2 = SEL2_S;
                c.h  = OP_ADD;
                c.ls = 1'b1;
            end
            ST_SUBC: begin
                c.m0 = SEL0_C;
                c.m1 = SEL1_S;
                c.m2 = SEL2_MUX0;
                c.h  = OP_SUB;
                c.ls = 1'b1;
            end
            ST_DONE: c.pronto = 1'b1;
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

    // n is captured only when a start is accepted, so later changes on n
    // and inicio pulses while busy have no effect.
    assign cnt_carga = (state == ST_IDLE) && bus.inicio;
    assign cnt_dec   = (state == ST_LOOP);

    controle_contador #(
        .N_W (N_W)
    ) u_contador (
        .ck    (ck),
        .rst   (rst),
        .carga (cnt_carga),
        .dec   (cnt_dec),
        .d     (bus.n),
        .cnt   (cnt),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.inicio) state_nxt = ST_LOADX;
            ST_LOADX: state_nxt = ST_CALCH;
            ST_CALCH: state_nxt = ST_CLRS;
            ST_CLRS:  state_nxt = cnt_zero ? ST_ADDA : ST_LOOP;
            // Leaving on cnt==1 (not 0) keeps LOOP to exactly n cycles and
            // means the counter never wraps, even for n = 2^N_W-1.
            ST_LOOP:  if (cnt == CNT_UM) state_nxt = ST_ADDA;
            ST_ADDA:  state_nxt = ST_SUBC;
            ST_SUBC:  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign ctrl        = decode(state);
    assign bus.lx      = ctrl.lx;
    assign bus.m0      = ctrl.m0;
    assign bus.m1      = ctrl.m1;
    assign bus.m2      = ctrl.m2;
    assign bus.h       = ctrl.h;
    assign bus.ls      = ctrl.ls;
    assign bus.lh      = ctrl.lh;
    assign bus.pronto  = ctrl.pronto;
    assign bus.ocupado = (state != ST_IDLE);
endmodule

// File: tb/tb_controle.sv
// tb_controle -- bench for controle driving a behavioural operativo datapath.
// Expected results and pronto cycles come from a vector table; outputs are
// checked cycle by cycle against the published state schedule.
module tb_controle;

    localparam int N_W = 4;

    logic ck;
    logic rst;
    logic [15:0] xin, ain, bin, cin;

    controle_if #(.N_W(N_W)) bus ();

    controle #(.N_W(N_W)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Operativo datapath model
    logic [15:0] rx, rs, rh, mux0, lft, rgt, ula;

    always_comb begin
        mux0 = '0;
        case (bus.m0)
            2'b00:   mux0 = '0;
            2'b01:   mux0 = ain;
            2'b10:   mux0 = bin;
            default: mux0 = cin;
        endcase
        lft = '0;
        case (bus.m1)
            2'b00:   lft = mux0;
            2'b01:   lft = rx;
            2'b10:   lft = rs;
            default: lft = rh;
        endcase
        rgt = '0;
        case (bus.m2)
            2'b00:   rgt = rx;
            2'b01:   rgt = mux0;
            2'b10:   rgt = rs;
            default: rgt = rh;
        endcase
        ula = bus.h ? (lft - rgt) : (lft + rgt);
    end

    always @(posedge ck) begin
        if (bus.lx) rx <= xin;
        if (bus.ls) rs <= ula;
        if (bus.lh) rh <= ula;
    end

    // Checking infrastructure
    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        int          n;
        logic [15:0] x, a, b, c;
        logic [15:0] res;
        int          cyc;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {bus.lx, bus.m0, bus.m1, bus.m2, bus.h, bus.ls, bus.lh,
                bus.pronto, bus.ocupado};
    endfunction

    // Expected {lx,m0,m1,m2,h,ls,lh,pronto,ocupado} in cycle c of a run
    // with count nn (cycle 1 = first cycle after inicio is sampled).
    function automatic logic [11:0] exp_out(input int c, input int nn);
        logic [11:0] e;
        e = '0;
        if (c == 1)                       e = 12'b1_00_00_00_0_0_0_0_1;
        else if (c == 2)                  e = 12'b0_10_00_00_0_0_1_0_1;
        else if (c == 3)                  e = 12'b0_00_00_01_0_1_0_0_1;
        else if (c >= 4 && c <= 3 + nn)   e = 12'b0_00_10_11_0_1_0_0_1;
        else if (c == 4 + nn)             e = 12'b0_01_00_10_0_1_0_0_1;
        else if (c == 5 + nn)             e = 12'b0_11_10_01_1_1_0_0_1;
        else if (c == 6 + nn)             e = 12'b0_00_00_00_0_0_0_1_1;
        return e;
    endfunction

    task automatic start(input vec_t v);
        @(negedge ck);
        bus.n      = v.n[N_W-1:0];
        xin        = v.x;
        ain        = v.a;
        bin        = v.b;
        cin        = v.c;
        bus.inicio = 1'b1;
    endtask

    task automatic run(input vec_t v, input bit repulse);
        exp_t e;
        bit   got;
        start(v);
        e.res = v.res;
        e.cyc = v.cyc;
        sbq.push_back(e);
        @(negedge ck);
        bus.inicio = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c > 1) @(negedge ck);
            chk($sformatf("outs n=%0d cyc%0d", v.n, c), 32'(outs()), 32'(exp_out(c, v.n)));
            if (bus.pronto) begin
                got = 1'b1;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk($sformatf("result n=%0d", v.n), 32'(rs), 32'(e.res));
                    chk($sformatf("pronto cycle n=%0d", v.n), 32'(c), 32'(e.cyc));
                end
            end
            if (repulse) begin
                bus.inicio = (c == 2 || c == 5);
                bus.n      = (c == 2 || c == 5) ? 4'd7 : v.n[N_W-1:0];
            end
        end
        bus.inicio = 1'b0;
        if (!got) begin
            chk($sformatf("timeout pronto n=%0d", v.n), 32'(0), 32'(1));
            sbq.delete();
        end
        @(negedge ck);
        chk($sformatf("pulse end n=%0d", v.n), 32'({bus.pronto, bus.ocupado}), 32'(0));
        chk($sformatf("result hold n=%0d", v.n), 32'(rs), 32'(v.res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{n: 3,  x: 16'd5,      a: 16'd10, b: 16'd2, c: 16'd4, res: 16'h001B, cyc: 9};
        tbl[1] = '{n: 0,  x: 16'd100,    a: 16'd3,  b: 16'd1, c: 16'd7, res: 16'hFFFC, cyc: 6};
        tbl[2] = '{n: 15, x: 16'h1000,   a: 16'd0,  b: 16'd0, c: 16'd0, res: 16'hF000, cyc: 21};
        tbl[3] = '{n: 1,  x: 16'd1,      a: 16'd0,  b: 16'd1, c: 16'd0, res: 16'h0002, cyc: 7};
        tbl[4] = '{n: 2,  x: 16'hFFFF,   a: 16'd0,  b: 16'd2, c: 16'd1, res: 16'h0001, cyc: 8};

        rst = 1'b1;
        bus.inicio = 1'b0;
        bus.n = '0;
        xin = '0; ain = '0; bin = '0; cin = '0;
        @(negedge ck);
        @(negedge ck);
        chk("reset outputs", 32'(outs()), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run(tbl[i], 1'b0);

        // inicio re-pulsed while busy, n changed after capture
        run(tbl[0], 1'b1);

        // reset in cycle 5 of an n=3 run, with inicio also high (rst wins)
        start(tbl[0]);
        @(negedge ck);
        bus.inicio = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge ck);
            chk($sformatf("pre-reset cyc%0d", c), 32'(outs()), 32'(exp_out(c, 3)));
        end
        rst = 1'b1;
        bus.inicio = 1'b1;
        @(negedge ck);
        chk("after reset outputs", 32'(outs()), 32'(0));
        rst = 1'b0;
        bus.inicio = 1'b0;
        run(tbl[0], 1'b0);

        // inicio held high: IDLE the cycle after DONE, then a new LOADX
        start(tbl[3]);
        for (int c = 1; c <= 9; c++) begin
            @(negedge ck);
            if (c == 7) begin
                chk("held: pronto", 32'(bus.pronto), 32'(1));
                chk("held: result", 32'(rs), 32'(16'h0002));
            end
            if (c == 8) chk("held: idle after done", 32'(outs()), 32'(0));
            if (c == 9) chk("held: restart loadx", 32'(outs()), 32'(exp_out(1, 1)));
        end
        bus.inicio = 1'b0;
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        chk("final reset outputs", 32'(outs()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
